// File: rtl/systolic_pkg.sv
// Shared types and constants for the weight-stationary array sequencer.
// Bus offsets are flat bit positions into the row-major weight bus.
package systolic_pkg;

    localparam int N_DEF     = 4;
    localparam int WIDTH_DEF = 16;
    localparam int CNTW_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic int bus_off(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// Zero-reset shift register of DEPTH stages; used for per-column skew
// and for the one-bit result tag pipeline.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary NxN PE array: loads weights, skews
// activation vectors onto the top edge and captures row-edge results.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD_W | accepting N*N weights, row-major
// S_STREAM | accepting activation vectors (bubbles fill gaps)
// S_DRAIN  | all vectors issued, waiting for results to retire
// S_DONE   | single cycle before returning to idle
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNTW-1:0]        num_vec,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [WIDTH-1:0]       w_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [N*WIDTH-1:0]     a_data,
    output logic [N*N*WIDTH-1:0]   weight_bus,
    output logic [N*WIDTH-1:0]     col_in,
    input  logic [N*WIDTH-1:0]     row_out,
    output logic                   y_valid,
    output logic [N*WIDTH-1:0]     y_data,
    output logic                   busy,
    output logic                   done
);

    localparam int IDXW = $clog2(N*N) + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNTW-1:0]      r_num_vec;
    logic [CNTW-1:0]      r_issued;
    logic [CNTW-1:0]      r_retired;
    logic [IDXW-1:0]      r_widx;
    logic [N*N*WIDTH-1:0] r_weight_bus;
    logic [N*WIDTH-1:0]   r_y_data;
    logic                 r_y_valid;
    logic                 r_done;

    logic                 w_w_fire;
    logic                 w_a_fire;
    logic                 w_last_w;
    logic                 w_tag_out;
    logic [CNTW:0]        w_retired_nxt;

    assign w_w_fire      = w_valid && w_ready;
    assign w_a_fire      = a_valid && a_ready;
    assign w_last_w      = (r_widx == IDXW'(N*N-1));
    // Counts the result retiring this cycle so DONE lines up with the last y_valid edge.
    assign w_retired_nxt = {1'b0, r_retired} + {{CNTW{1'b0}}, w_tag_out};

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && w_last_w) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                a_ready = (r_issued < r_num_vec);
                if (r_issued == r_num_vec) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_retired_nxt == {1'b0, r_num_vec}) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num_vec    <= '0;
            r_issued     <= '0;
            r_retired    <= '0;
            r_widx       <= '0;
            r_weight_bus <= '0;
            r_y_data     <= '0;
            r_y_valid    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_num_vec <= num_vec;
                r_issued  <= '0;
                r_retired <= '0;
                r_widx    <= '0;
            end
            if (w_w_fire) begin
                r_weight_bus[bus_off(int'(r_widx) / N, int'(r_widx) % N, N, WIDTH) +: WIDTH] <= w_data;
                r_widx <= w_last_w ? '0 : r_widx + 1'b1;
            end
            if (w_a_fire) r_issued <= r_issued + 1'b1;
            r_y_valid <= w_tag_out;
            if (w_tag_out) begin
                r_y_data  <= row_out;
                r_retired <= r_retired + 1'b1;
            end
            r_done <= (r_state == S_DONE);
        end
    end

    // Column c sees a vector c edges after acceptance; the tag lands when row sums are final.
    for (genvar c = 0; c < N; c++) begin : g_col
        skew_line #(.DEPTH(c + 1), .WIDTH(WIDTH)) u_skew (
            .clk   (clk),
            .rst_n (rst),
            .i_d   (w_a_fire ? a_data[c*WIDTH +: WIDTH] : {WIDTH{1'b0}}),
            .o_q   (col_in[c*WIDTH +: WIDTH])
        );
    end

    skew_line #(.DEPTH(N + 1), .WIDTH(1)) u_tag (
        .clk   (clk),
        .rst_n (rst),
        .i_d   (w_a_fire),
        .o_q   (w_tag_out)
    );

    assign weight_bus = r_weight_bus;
    assign y_valid    = r_y_valid;
    assign y_data     = r_y_data;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the weight-stationary N×N PE array.
- Loads the N×N weight matrix from a stream and holds it stable on the array's per-PE weight inputs.
- Skews accepted activation vectors onto the array's top edge and captures each row-edge result vector with exactly matching timing.
- Sits between the NPU's stream interfaces and the array top level, which instantiates this block plus the PE grid and ties every column-0 `in_left` to zero.

## Interface
Parameters:
- `N`, 4: array dimension, rows = columns.
- `WIDTH`, 16: signed data width of weights, activations and sums.
- `CNTW`, 8: width of the vector counters and of `num_vec`.

Ports:
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `rst`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Begin a job; sampled only in IDLE.
- `num_vec`  in  CNTW  Number of activation vectors in the job; latched on `start`.
- `w_valid` / `w_ready` / `w_data`  in/out/in  1/1/WIDTH  Weight stream, row-major, N·N beats.
- `a_valid` / `a_ready` / `a_data`  in/out/in  1/1/N·WIDTH  Activation vectors; element c in bits [c·WIDTH +: WIDTH].
- `weight_bus`  out  N·N·WIDTH  Weight for PE(r,c) in bits [(r·N+c)·WIDTH +: WIDTH]; registered.
- `col_in`  out  N·WIDTH  Skewed top-edge `in_up` values for each column; registered.
- `row_out`  in  N·WIDTH  `out_right` of PE(r,N−1) for each row r.
- `y_valid` / `y_data`  out/out  1/N·WIDTH  Result vector; no backpressure.
- `busy`  out  1  High whenever state ≠ IDLE.
- `done`  out  1  One-cycle pulse at job end.

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE
  - On `start`: latch `num_vec`, clear counters, go to LOAD_W.
  - `start` in any other state is ignored.
- LOAD_W
  - `w_ready`=1; each handshake writes weight[idx/N][idx%N] and increments idx.
  - On handshake N·N go to STREAM.
  - `weight_bus` holds its value in every other state; it is not cleared between jobs.
- STREAM
  - `a_ready` = (issued < num_vec).
  - Each handshake loads the vector into the skew lines with tag 1.
  - A cycle with no handshake loads zeros with tag 0 (bubble).
  - When issued == num_vec, go to DRAIN. With `num_vec`=0 this happens the cycle after entering STREAM.
- DRAIN
  - Skew lines keep shifting zeros.
  - When retired == num_vec and no tag is in flight, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Skew: column c passes through a delay of c+1 registers, so a vector accepted at edge E reaches column c at edge E+c.
- Tag pipeline: N+1 stages. When its output is 1, capture `row_out` into `y_data`, assert `y_valid`, and increment retired.
- Arithmetic: the block does no arithmetic on data. Sums are the array's WIDTH-bit two's-complement wrap, passed through unchanged.

## Timing
- Reset values: state IDLE; `w_ready`, `a_ready`, `y_valid`, `busy`, `done` = 0; `weight_bus`, `col_in`, `y_data`, all skew/tag stages and counters = 0.
- `w_ready` rises the edge after the `start` edge.
- `y_valid` for a vector rises exactly N+1 edges after its `a` handshake edge.
- Results come out in acceptance order. Bubbles preserve spacing: back-to-back handshakes give back-to-back `y_valid`.
- Job end: `done` asserts N+2 edges after the last `a` handshake, and `busy` drops on the same edge.
- Reset asserted mid-job: all state clears immediately, including in-flight vectors. No `y_valid` or `done` follows.

## Structure
- `systolic_pkg` holds:
  - the state enum;
  - default N / WIDTH / CNTW constants;
  - a function returning a bus slice index (r, c → bit offset).
- Sub-module `skew_line #(DEPTH, WIDTH)`: a zero-reset shift register, instantiated once per column with DEPTH = c+1. The tag pipeline uses the same module with WIDTH=1.

## Test plan
Bench instantiates the controller with a 4×4 PE grid and WIDTH=16.
- Identity load: weights = identity, `num_vec`=3, vectors (1,2,3,4),(5,6,7,8),(−1,0,0,9) → `y_data` equals each input, `y_valid` at handshake+5, `done` once.
- General matrix: weights w[r][c]=r+c, vector (1,1,1,1) → y = (6,10,14,18).
- Bubbles: `a_valid` toggles 1,0,0,1 → the two results are spaced 3 cycles apart, and no `y_valid` appears for the bubble cycles.
- Overflow: all weights 0x4000, vector (2,0,0,0) → y row values 0x8000 (wrap), no saturation.
- `num_vec`=0 and `start` during STREAM → the zero job ends with `done` after weight load and no `y_valid`; the mid-job `start` is ignored.
- Reset asserted in DRAIN → all outputs 0 next cycle; a new job afterwards produces correct results.
